// File: rtl/hpm_counter_bank_if.sv
// CSR access port of the HPM counter bank: one write channel and one
// combinational read channel shared by the CSR unit.
interface hpm_counter_bank_if #(
    parameter int IDX_W = 3
);
    logic             wr_valid;
    logic             wr_sel;
    logic [IDX_W-1:0] wr_idx;
    logic [63:0]      wr_data;
    logic [1:0]       rd_sel;
    logic [IDX_W-1:0] rd_idx;
    logic [63:0]      rd_data;

    // CSR unit side
    modport master (
        output wr_valid, wr_sel, wr_idx, wr_data, rd_sel, rd_idx,
        input  rd_data
    );

    // Counter bank side
    modport slave (
        input  wr_valid, wr_sel, wr_idx, wr_data, rd_sel, rd_idx,
        output rd_data
    );
endinterface

// File: rtl/hpm_counter_bank.sv
// Hardware performance-monitor counter bank.
// NUM_COUNTERS generic counters, each with its own event-select register,
// inhibit bit and sticky overflow flag. Counters accumulate multi-count
// per-cycle event increments; any overflow raises lcofi_irq one cycle later.
// Optional feature: define HPM_SNAPSHOT_EN to add the snap_req input and a
// shadow register per counter, readable through rd_sel = 2.
module hpm_counter_bank #(
    parameter int NUM_COUNTERS = 8,
    parameter int CNT_WIDTH    = 64,
    parameter int NUM_EVENTS   = 16,
    parameter int INC_W        = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_EVENTS*INC_W-1:0]  evt_inc,
    input  logic [NUM_COUNTERS-1:0]      inhibit,
`ifdef HPM_SNAPSHOT_EN
    input  logic                         snap_req,
`endif
    hpm_counter_bank_if.slave            csr,
    output logic [NUM_COUNTERS-1:0]      of_vec,
    output logic                         lcofi_irq
);

    localparam int IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam int SEL_W = $clog2(NUM_EVENTS + 1);

    // Unpacked view of the event increments, one entry per event
    logic [INC_W-1:0]     evt_arr  [NUM_EVENTS];
    // Per-counter state gathered for the read mux
    logic [CNT_WIDTH-1:0] cnt_q    [NUM_COUNTERS];
    logic [SEL_W-1:0]     sel_q    [NUM_COUNTERS];
`ifdef HPM_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_q [NUM_COUNTERS];
`endif
    logic                 lcofi_reg;
    logic [63:0]          rd_mux;

    genvar gi;

    for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_evt
        assign evt_arr[gi] = evt_inc[gi*INC_W +: INC_W];
    end

    for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
        logic [SEL_W-1:0]     sel_reg, sel_next;
        logic                 of_reg, of_next;
        logic [INC_W-1:0]     inc;
        logic                 sel_ok;
        logic [CNT_WIDTH:0]   sum;
        logic                 wr_hit;

        // Pick the selected event's increment; sel 0 or beyond NUM_EVENTS never matches
        always_comb begin
            inc    = '0;
            sel_ok = 1'b0;
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (sel_reg == SEL_W'(k + 1)) begin
                    inc    = evt_arr[k];
                    sel_ok = 1'b1;
                end
            end
        end

        // Out-of-range write indices never match any generated counter
        assign wr_hit = csr.wr_valid && (csr.wr_idx == IDX_W'(gi));
        assign sum    = {1'b0, cnt_reg} + (CNT_WIDTH+1)'(inc);

        // Next state: counting first, then a counter write overrides it,
        // and an event write owns sel and OF (written OF beats a same-cycle carry)
        always_comb begin
            cnt_next = cnt_reg;
            sel_next = sel_reg;
            of_next  = of_reg;
            if (sel_ok && !inhibit[gi]) begin
                cnt_next = sum[CNT_WIDTH-1:0];
                if (sum[CNT_WIDTH]) begin
                    of_next = 1'b1;
                end
            end
            if (wr_hit && !csr.wr_sel) begin
                cnt_next = csr.wr_data[CNT_WIDTH-1:0];
                of_next  = of_reg;
            end
            if (wr_hit && csr.wr_sel) begin
                sel_next = csr.wr_data[SEL_W-1:0];
                of_next  = csr.wr_data[63];
            end
        end

        // Counter, select and overflow state registers
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
                sel_reg <= '0;
                of_reg  <= 1'b0;
            end else begin
                cnt_reg <= cnt_next;
                sel_reg <= sel_next;
                of_reg  <= of_next;
            end
        end

`ifdef HPM_SNAPSHOT_EN
        logic [CNT_WIDTH-1:0] shadow_reg;

        // Shadow captures the pre-edge counter value on a snapshot request
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                shadow_reg <= '0;
            end else if (snap_req) begin
                shadow_reg <= cnt_reg;
            end
        end

        assign shadow_q[gi] = shadow_reg;
`endif

        assign cnt_q[gi]  = cnt_reg;
        assign sel_q[gi]  = sel_reg;
        assign of_vec[gi] = of_reg;
    end

    // Interrupt request follows the OR of the overflow flags one cycle late
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lcofi_reg <= 1'b0;
        end else begin
            lcofi_reg <= |of_vec;
        end
    end

    assign lcofi_irq = lcofi_reg;

    // Combinational read of current state; unmatched index or target reads 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (csr.rd_idx == IDX_W'(i)) begin
                case (csr.rd_sel)
                    2'd0:    rd_mux = 64'(cnt_q[i]);
                    2'd1:    rd_mux = {of_vec[i], 63'(sel_q[i])};
`ifdef HPM_SNAPSHOT_EN
                    2'd2:    rd_mux = 64'(shadow_q[i]);
`endif
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    assign csr.rd_data = rd_mux;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank: the stimulus thread pushes the
// expected read/flag values for each cycle, a negedge monitor pops and checks.
module tb_hpm_counter_bank;
    localparam int NC  = 6;
    localparam int NE  = 16;
    localparam int IW  = 3;
    localparam int IXW = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NE*IW-1:0] evt_inc = '0;
    logic [NC-1:0]    inhibit = '0;
    logic [NC-1:0]    of_vec;
    logic             lcofi_irq;
`ifdef HPM_SNAPSHOT_EN
    logic             snap_req = 1'b0;
`endif

    hpm_counter_bank_if #(.IDX_W(IXW)) csr_if ();

    hpm_counter_bank #(
        .NUM_COUNTERS(NC), .CNT_WIDTH(64), .NUM_EVENTS(NE), .INC_W(IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .evt_inc   (evt_inc),
        .inhibit   (inhibit),
`ifdef HPM_SNAPSHOT_EN
        .snap_req  (snap_req),
`endif
        .csr       (csr_if),
        .of_vec    (of_vec),
        .lcofi_irq (lcofi_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         nm;
        logic [63:0]   rd;
        bit            chk_flags;
        logic [NC-1:0] of;
        bit            irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Monitor: one expectation per cycle, checked mid-cycle
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            $display("vec %0d %s rd_data=%h of_vec=%b irq=%b", vectors, mon_e.nm,
                     csr_if.rd_data, of_vec, lcofi_irq);
            if (csr_if.rd_data !== mon_e.rd) begin
                miscompares++;
                $display("FAIL %s rd_data got %h want %h", mon_e.nm, csr_if.rd_data, mon_e.rd);
            end
            if (mon_e.chk_flags) begin
                if (of_vec !== mon_e.of) begin
                    miscompares++;
                    $display("FAIL %s of_vec got %b want %b", mon_e.nm, of_vec, mon_e.of);
                end
                if (lcofi_irq !== mon_e.irq) begin
                    miscompares++;
                    $display("FAIL %s lcofi_irq got %b want %b", mon_e.nm, lcofi_irq, mon_e.irq);
                end
            end
        end
    end

    task automatic wr(input bit s, input logic [IXW-1:0] i, input logic [63:0] d);
        csr_if.wr_valid = 1'b1;
        csr_if.wr_sel   = s;
        csr_if.wr_idx   = i;
        csr_if.wr_data  = d;
    endtask

    task automatic set_evt(input int k, input logic [IW-1:0] v);
        evt_inc[k*IW +: IW] = v;
    endtask

    // Drive the read port, queue the expectation, advance one clock
    task automatic cyc_x(input string nm, input logic [1:0] rs, input logic [IXW-1:0] ri,
                         input logic [63:0] erd, input bit cf,
                         input logic [NC-1:0] eof, input bit eirq);
        exp_t e;
        csr_if.rd_sel = rs;
        csr_if.rd_idx = ri;
        e.nm = nm; e.rd = erd; e.chk_flags = cf; e.of = eof; e.irq = eirq;
        sb.push_back(e);
        @(posedge clock);
        #1;
        csr_if.wr_valid = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [1:0] rs, input logic [IXW-1:0] ri,
                       input logic [63:0] erd);
        cyc_x(nm, rs, ri, erd, 1'b0, '0, 1'b0);
    endtask

    task automatic cyc_f(input string nm, input logic [1:0] rs, input logic [IXW-1:0] ri,
                         input logic [63:0] erd, input logic [NC-1:0] eof, input bit eirq);
        cyc_x(nm, rs, ri, erd, 1'b1, eof, eirq);
    endtask

    initial begin
        csr_if.wr_valid = 1'b0;
        csr_if.wr_sel   = 1'b0;
        csr_if.wr_idx   = '0;
        csr_if.wr_data  = '0;
        csr_if.rd_sel   = '0;
        csr_if.rd_idx   = '0;
        repeat (2) @(posedge clock);
        #1;
        cyc_f("reset_state", 0, 0, 64'd0, 6'b0, 1'b0);
        reset = 1'b0;

        // Reset mid-count: counter 0 counts event 0 at 3/cycle
        wr(1, 0, 64'd1);
        cyc_f("mid_sel_wr", 0, 0, 64'd0, 6'b0, 1'b0);
        set_evt(0, 3);
        for (int n = 0; n < 5; n++) cyc("mid_count", 0, 0, 64'(3 * n));
        evt_inc = '0;
        cyc("mid_15", 0, 0, 64'd15);
        reset = 1'b1;
        cyc_f("mid_async_reset", 0, 0, 64'd0, 6'b0, 1'b0);
        reset = 1'b0;
        cyc("mid_evt_cleared", 1, 0, 64'd0);

        // Overflow on counter 2
        wr(0, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc("ovf_wr_cnt", 0, 2, 64'd0);
        wr(1, 2, 64'd1);
        set_evt(0, 3);
        cyc("ovf_wr_sel", 0, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc_f("ovf_pre", 0, 2, 64'hFFFF_FFFF_FFFF_FFFE, 6'b0, 1'b0);
        evt_inc = '0;
        cyc_f("ovf_wrap", 0, 2, 64'd1, 6'b000100, 1'b0);
        wr(1, 2, 64'd1);
        cyc_f("ovf_irq_clrwr", 1, 2, 64'h8000_0000_0000_0001, 6'b000100, 1'b1);
        cyc_f("ovf_of_clr", 1, 2, 64'd1, 6'b0, 1'b1);
        cyc_f("ovf_irq_clr", 0, 2, 64'd1, 6'b0, 1'b0);

        // Write vs increment collision on counter 1 (event 1, 2/cycle)
        wr(1, 1, 64'd2);
        cyc("col_sel", 0, 1, 64'd0);
        set_evt(1, 2);
        cyc("col_c0", 0, 1, 64'd0);
        cyc("col_c2", 0, 1, 64'd2);
        wr(0, 1, 64'd100);
        cyc("col_wr", 0, 1, 64'd4);
        cyc("col_100", 0, 1, 64'd100);
        cyc("col_102", 0, 1, 64'd102);
        evt_inc = '0;

        // Inhibit and invalid select on counter 3 (event 4)
        wr(1, 3, 64'd5);
        cyc("inh_sel", 0, 3, 64'd0);
        inhibit = 6'b001000;
        set_evt(4, 7);
        cyc("inh_a", 0, 3, 64'd0);
        cyc("inh_b", 0, 3, 64'd0);
        inhibit = '0;
        cyc("inh_release", 0, 3, 64'd0);
        inhibit = 6'b001000;
        wr(0, 3, 64'd20);
        cyc("inh_wr", 0, 3, 64'd7);
        cyc("inh_wr_taken", 0, 3, 64'd20);
        inhibit = '0;
        evt_inc = '1;
        wr(1, 3, 64'd17);
        cyc("bad_sel_wr", 0, 3, 64'd20);
        cyc("bad_sel_rd", 1, 3, 64'd17);
        cyc("bad_sel_hold", 0, 3, 64'd27);
        evt_inc = '0;
        cyc("rd_sel3", 3, 3, 64'd0);

        // Out-of-range write and read indices
        wr(0, 6, 64'd123);
        cyc("oor_rd", 0, 6, 64'd0);
        wr(1, 6, 64'h8000_0000_0000_0001);
        cyc("oor_c0", 0, 0, 64'd0);
        cyc_f("oor_c3", 0, 3, 64'd27, 6'b0, 1'b0);

        // Event-select switch on counter 4
        wr(1, 4, 64'd1);
        cyc("sw_sel1", 0, 4, 64'd0);
        set_evt(0, 1);
        set_evt(1, 4);
        cyc("sw_c0", 0, 4, 64'd0);
        wr(1, 4, 64'd2);
        cyc("sw_wr", 0, 4, 64'd1);
        cyc("sw_old_sel", 0, 4, 64'd2);
        evt_inc = '0;
        cyc("sw_new_sel", 0, 4, 64'd6);
        cyc("sw_evt_rd", 1, 4, 64'd2);

        // Snapshot register
        wr(0, 0, 64'd50);
        cyc("snap_wr50", 0, 0, 64'd0);
`ifdef HPM_SNAPSHOT_EN
        snap_req = 1'b1;
        wr(0, 0, 64'd0);
        cyc("snap_req", 0, 0, 64'd50);
        snap_req = 1'b0;
        cyc("snap_shadow", 2, 0, 64'd50);
        cyc("snap_cnt", 0, 0, 64'd0);
`else
        cyc("snap_absent", 2, 0, 64'd0);
        cyc("snap_cnt", 0, 0, 64'd50);
`endif

        for (int n = 0; n < 10 && sb.size() > 0; n++) begin
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
- Parametrised performance-counter bank; next generation of the single free-running cycle counter in the CSR register file.
- Holds NUM_COUNTERS generic counters. Each counter has its own event-select register, inhibit bit and sticky overflow flag.
- Counters advance by multi-count per-cycle event increments, so several retirements can be counted in one cycle.
- Sits beside the CSR register file. The CSR unit reads and writes it through one port; pipeline and memory units drive event increments; it raises a local counter-overflow interrupt request toward the interrupt logic.

Parameters:
- NUM_COUNTERS, 8, number of counters (1..32).
- CNT_WIDTH, 64, counter width in bits (1..64); reads are zero-extended to 64.
- NUM_EVENTS, 16, number of event inputs (1..255).
- INC_W, 3, width of each per-cycle event increment.
- Derived localparam IDX_W = max(1, $clog2(NUM_COUNTERS)).
- Derived localparam SEL_W = $clog2(NUM_EVENTS+1).

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- evt_inc  in  NUM_EVENTS*INC_W  packed per-event increment for this cycle; event k occupies bits [k*INC_W +: INC_W]
- inhibit  in  NUM_COUNTERS  per-counter count inhibit (mcountinhibit image)
- wr_valid  in  1  CSR write strobe
- wr_sel  in  1  write target: 0 = counter, 1 = event register
- wr_idx  in  IDX_W  write target index
- wr_data  in  64  write data
- rd_sel  in  2  read target: 0 = counter, 1 = event register, 2 = snapshot (optional feature), 3 = reserved
- rd_idx  in  IDX_W  read index
- rd_data  out  64  read data, combinational from current state
- of_vec  out  NUM_COUNTERS  registered overflow flags
- lcofi_irq  out  1  registered OR of of_vec

Behaviour:
- Reset (async): all counters 0, all event registers 0, of_vec 0, lcofi_irq 0, snapshots 0.
- Event register layout: bits [SEL_W-1:0] = sel; bit 63 = OF; all other bits read 0 and ignore writes.
- Event select:
  - sel = 0 means no counting.
  - sel = k with 1 <= k <= NUM_EVENTS counts event k-1.
  - sel > NUM_EVENTS means no counting.
- Per cycle, per counter i, when not inhibit[i] and sel valid: cnt_next = cnt + zero_ext(evt_inc[sel-1]), computed in CNT_WIDTH+1 bits.
- Overflow: if the carry bit of the sum is 1, the counter keeps the low CNT_WIDTH bits and OF is set (sticky). OF clears only by a CSR write of bit 63 = 0.
- Write to counter i (wr_sel = 0):
  - The counter takes wr_data[CNT_WIDTH-1:0] at the next edge.
  - That cycle's increment for counter i is discarded; the write always wins.
  - No overflow is generated that cycle.
- Write to event register i (wr_sel = 1):
  - sel and OF both load from wr_data.
  - The new sel takes effect from the following cycle.
  - The same-cycle increment uses the old sel.
  - If that increment overflows, the written OF value still wins.
- Write with wr_idx >= NUM_COUNTERS: ignored, no state change.
- Reads:
  - Combinational, zero latency, return pre-edge state; a same-cycle write is not forwarded.
  - rd_idx out of range returns 0; rd_sel = 3 returns 0.
- lcofi_irq: registered; equals |of_vec as of the previous edge, i.e. 1 cycle after OF sets.
- Inhibit: takes effect in the same cycle it is sampled. CSR writes are accepted while inhibited.
- Wrap: all-ones + 1 gives 0 and sets OF. The counter keeps counting after OF is set.

Optional Feature:
- Macro HPM_SNAPSHOT_EN.
- With the macro defined:
  - Extra input snap_req (1 bit).
  - When snap_req = 1, every shadow register captures the pre-edge counter value at the edge.
  - rd_sel = 2 reads shadow[rd_idx].
  - A same-cycle write or increment does not affect the captured value.
- Without the macro: no snap_req port, no shadow registers, rd_sel = 2 returns 0.

Test Plan:
- Reset mid-count: counter 0 at sel=1, evt_inc[0]=3 for 5 cycles, then assert reset -> rd_data goes 15, then 0 immediately on reset; of_vec = 0, lcofi_irq = 0.
- Overflow: CNT_WIDTH=64, write counter 2 = 0xFFFF_FFFF_FFFF_FFFE, sel=1, evt_inc[0]=3 -> counter = 1, of_vec[2] = 1, lcofi_irq = 1 one cycle later; write event 2 with bit63=0 -> of_vec[2] = 0, then lcofi_irq = 0.
- Write-vs-increment collision: counter 1 counting 2/cycle; write 100 in cycle N -> reads 100 after edge N, then 102.
- Inhibit and invalid sel: inhibit[3]=1 with evt_inc[4]=7 -> counter 3 unchanged; sel=NUM_EVENTS+1 -> unchanged; wr_idx=NUM_COUNTERS -> no state change.
- Event-select switch: sel changes 1->2 while evt_inc[0]=1, evt_inc[1]=4 -> write cycle adds 1, following cycles add 4.
- HPM_SNAPSHOT_EN: counter 0 = 50 with snap_req and a write of 0 in the same cycle -> rd_sel=2 returns 50, rd_sel=0 returns 0.
